// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: FSM state encodings and
// request-direction values carried on ReqWrite.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam int WAIT_CNT_W = 4;

    function automatic logic isWordAligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_word_ram.sv
// DEPTH_WORDS x 32 word store with synchronous write, registered read,
// reset-to-zero contents and a byte-address range check.
module data_mem_responder_word_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic        rdZero,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    output logic        addrOk,
    output logic [31:0] rData
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]      memWords [DEPTH_WORDS];
    logic [IDX_W-1:0] wordIdx;

    assign addrOk  = addr < 32'(DEPTH_WORDS * 4);
    assign wordIdx = addr[IDX_W+1:2];

    // Each word is its own register so the whole array can clear in one reset edge.
    generate
        for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
            always_ff @(posedge CLK) begin
                if (Reset) begin
                    memWords[gi] <= '0;
                end else if (wrEn && addrOk && (wordIdx == IDX_W'(gi))) begin
                    memWords[gi] <= wData;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rData <= '0;
        end else if (rdEn) begin
            rData <= (rdZero || !addrOk) ? 32'd0 : memWords[wordIdx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder: captures one request, waits a fixed
// number of cycles, then holds the response until the initiator takes it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    resp_state_t           stateReg, stateNext;
    logic [WAIT_CNT_W-1:0] countReg, countNext;
    logic                  writeReg;
    logic [31:0]           addrReg;
    logic [31:0]           wdataReg;
    logic                  errReg;

    logic accept;
    logic serve;
    logic addrOk;
    logic reqErr;

    assign reqErr = !isWordAligned(addrReg) || !addrOk;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateReg <= ST_IDLE;
            countReg <= '0;
            writeReg <= REQ_READ;
            addrReg  <= '0;
            wdataReg <= '0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
            if (accept) begin
                writeReg <= ReqWrite;
                addrReg  <= ReqAddr;
                wdataReg <= ReqWData;
            end
            if (serve) begin
                errReg <= reqErr;
            end
        end
    end

    // The accept edge itself spends one cycle in WAIT, so the response
    // appears WAIT_CYCLES+1 edges after acceptance (one edge when zero).
    always_comb begin
        stateNext = stateReg;
        countNext = countReg;
        ReqReady  = 1'b0;
        RespValid = 1'b0;
        accept    = 1'b0;
        serve     = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    accept    = 1'b1;
                    stateNext = ST_WAIT;
                    countNext = WAIT_CNT_W'(WAIT_CYCLES);
                end
            end
            ST_WAIT: begin
                if (countReg == '0) begin
                    serve     = 1'b1;
                    stateNext = ST_RESP;
                end else begin
                    countNext = countReg - 1'b1;
                end
            end
            ST_RESP: begin
                RespValid = 1'b1;
                if (RespReady) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    data_mem_responder_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_word_ram (
        .CLK   (CLK),
        .Reset (Reset),
        .wrEn  (serve && (writeReg == REQ_WRITE) && !reqErr),
        .rdEn  (serve),
        .rdZero((writeReg == REQ_WRITE) || reqErr),
        .addr  (addrReg),
        .wData (wdataReg),
        .addrOk(addrOk),
        .rData (RespRData)
    );

    assign RespErr = errReg;

endmodule
